// File: rtl/mat_stream_host_if.sv
// AXI-Stream link shared by the operand (host -> accelerator) and result
// (accelerator -> host) streams.
interface mat_stream_host_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;

  modport master (output tvalid, tdata, tlast, tstrb, input tready);
  modport slave  (input tvalid, tdata, tlast, tstrb, output tready);
endinterface

// File: rtl/mat_stream_host.sv
// Host-side engine: streams operand matrices A then B to the accelerator,
// pulses start, then collects the result matrix with tlast/timeout checking.
module mat_stream_host #(
  parameter int DIM_LOG    = 1,
  parameter int DIM        = 2**DIM_LOG,
  parameter int SIZE       = DIM*DIM,
  parameter int SIZE_LOG   = 2*DIM_LOG,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [SIZE_LOG-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [SIZE_LOG-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  mat_stream_host_if.master     m00_axis,
  mat_stream_host_if.slave      s00_axis,
  output logic                  sel,
  output logic                  start
);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND_A = 3'd1;
  localparam logic [2:0] ST_SEND_B = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_RECV   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [SIZE_LOG-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0] mem_a_q [SIZE];
  logic [DATA_WIDTH-1:0] mem_b_q [SIZE];
  logic [DATA_WIDTH-1:0] mem_r_q [SIZE];

  logic cnt_last, m_hs, s_hs, in_send;

  // All handshake outputs decode straight from the state register, so reset
  // forces them low on the very next cycle.
  assign in_send  = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
  assign cnt_last = (cnt_q == SIZE_LOG'(SIZE-1));

  assign m00_axis.tvalid = in_send;
  assign m00_axis.tdata  = (state_q == ST_SEND_B) ? mem_b_q[cnt_q] : mem_a_q[cnt_q];
  assign m00_axis.tlast  = in_send && cnt_last;
  assign m00_axis.tstrb  = '1;
  assign s00_axis.tready = (state_q == ST_RECV);

  assign m_hs = m00_axis.tvalid && m00_axis.tready;
  assign s_hs = s00_axis.tvalid && s00_axis.tready;

  assign sel     = (state_q == ST_SEND_B) || (state_q == ST_START) || (state_q == ST_RECV);
  assign start   = (state_q == ST_START);
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = done_q;
  assign err     = err_q;
  assign rd_data = rd_data_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    done_d    = done_q;
    err_d     = err_q;
    rd_data_d = mem_r_q[rd_addr];
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_SEND_A;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 2'b00;
        end
      end
      ST_SEND_A, ST_SEND_B: begin
        if (m_hs) begin
          if (cnt_last) begin
            state_d = (state_q == ST_SEND_A) ? ST_SEND_B : ST_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SIZE_LOG'(1);
          end
        end
      end
      ST_START: begin
        state_d = ST_RECV;
        cnt_d   = '0;
        tmr_d   = '0;
      end
      ST_RECV: begin
        if (s_hs) begin
          tmr_d = '0;
          // tlast must coincide exactly with the final word; words after an
          // early tlast are still collected.
          if (s00_axis.tlast != cnt_last) err_d[0] = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SIZE_LOG'(1);
          end
        end else if (tmr_q == TMR_W'(TIMEOUT-1)) begin
          err_d[1] = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 2'b00;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffers keep their contents across reset; operand writes only when idle.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_areset) begin
      if (wr_en && !busy) begin
        if (wr_sel) mem_b_q[wr_addr] <= wr_data;
        else        mem_a_q[wr_addr] <= wr_data;
      end
      if (s_hs) mem_r_q[cnt_q] <= s00_axis.tdata;
    end
  end

endmodule

// File: tb/tb_mat_stream_host.sv
// Scoreboard bench: stream beats are predicted from a reference operand model
// and checked by a monitor; an accelerator model multiplies what it receives.
module tb_mat_stream_host;
  localparam int DIM_LOG = 1;
  localparam int DIM     = 2;
  localparam int SIZE    = 4;
  localparam int SL      = 2;
  localparam int DW      = 32;
  localparam int TMO     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, wr_sel = 1'b0, go = 1'b0;
  logic [SL-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic          busy, done, sel, start;
  logic [1:0]    err;
  logic          d_wr = 1'b0, d_go = 1'b0;

  always #5 clk = ~clk;

  mat_stream_host_if #(.DATA_WIDTH(DW)) m_if();
  mat_stream_host_if #(.DATA_WIDTH(DW)) s_if();

  mat_stream_host #(.DIM_LOG(DIM_LOG), .DIM(DIM), .SIZE(SIZE), .SIZE_LOG(SL),
                    .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .wr_en(wr_en | d_wr), .wr_sel(d_wr ? 1'b0 : wr_sel),
    .wr_addr(d_wr ? SL'(0) : wr_addr), .wr_data(d_wr ? 32'hDEAD_BEEF : wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .go(go | d_go),
    .busy(busy), .done(done), .err(err),
    .m00_axis(m_if), .s00_axis(s_if), .sel(sel), .start(start));

  int n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: operand contents and the product they should yield.
  logic [DW-1:0] ref_a [SIZE];
  logic [DW-1:0] ref_b [SIZE];
  logic [DW-1:0] exp_r [SIZE];

  function automatic void matmul(input logic [DW-1:0] a [SIZE], input logic [DW-1:0] b [SIZE],
                                 output logic [DW-1:0] r [SIZE]);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < DIM; k++) s = s + a[i*DIM+k] * b[k*DIM+j];
        r[i*DIM+j] = s;
      end
  endfunction

  typedef struct { logic sel; logic last; logic [DW-1:0] data; } beat_t;
  beat_t exp_q [$];

  int          rdy_mode = 0, acc_mode = 0;
  bit          dist_wr = 0, dist_go = 0;
  int unsigned start_cyc = 0, last_s_cyc = 0;
  int          start_cnt = 0, cap_idx = 0;
  logic [DW-1:0] cap_a [SIZE];
  logic [DW-1:0] cap_b [SIZE];

  // Stream monitor / scoreboard
  bit    stall_v = 0;
  beat_t stall_b;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_v = 0;
    end else begin
      if (go | d_go && !busy) begin cap_idx = 0; start_cnt = 0; end
      if (stall_v)
        chk("stall_hold", 64'({m_if.tvalid, sel, m_if.tlast, m_if.tdata}),
                          64'({1'b1, stall_b.sel, stall_b.last, stall_b.data}));
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) chk("beat_expected", 64'(exp_q.size()), 64'(1));
        else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat", 64'({sel, m_if.tlast, m_if.tdata}), 64'({b.sel, b.last, b.data}));
        end
        if (cap_idx < SIZE)        cap_a[cap_idx] = m_if.tdata;
        else if (cap_idx < 2*SIZE) cap_b[cap_idx-SIZE] = m_if.tdata;
        cap_idx++;
      end
      stall_v = m_if.tvalid && !m_if.tready;
      stall_b.sel = sel; stall_b.last = m_if.tlast; stall_b.data = m_if.tdata;
      if (start) begin start_cnt++; start_cyc = cyc; end
      if (s_if.tvalid && s_if.tready) last_s_cyc = cyc;
    end
  end

  // Operand sink readiness
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ~m_if.tready;
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Accelerator model: multiplies the matrices it received, returns results.
  initial begin
    logic [DW-1:0] res [SIZE];
    int n;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tstrb = '1;
    forever begin
      @(negedge clk);
      if (start && !rst && acc_mode != 2) begin
        matmul(cap_a, cap_b, res);
        for (int w = 0; w < SIZE; w++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          @(posedge clk); #1;
          s_if.tvalid = 1'b1; s_if.tdata = res[w];
          s_if.tlast = (acc_mode == 0) ? (w == SIZE-1) : (w == 1);
          n = 0;
          do begin @(negedge clk); n++; end while (!s_if.tready && n < 100);
          if (n >= 100) chk("result_accept_bound", 64'(n), 64'(0));
          @(posedge clk); #1;
          s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        end
      end
    end
  end

  // Disturbance: an operand write during SEND_A and a go during RECV.
  initial forever begin
    @(negedge clk);
    if (dist_wr && m_if.tvalid && !sel) begin
      dist_wr = 0;
      @(posedge clk); #1 d_wr = 1'b1;
      @(posedge clk); #1 d_wr = 1'b0;
    end else if (dist_go && s_if.tready) begin
      dist_go = 0;
      @(posedge clk); #1 d_go = 1'b1;
      @(posedge clk); #1 d_go = 1'b0;
    end
  end

  task automatic write_op(input logic s, input int addr, input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel = s; wr_addr = SL'(addr); wr_data = d;
    if (s) ref_b[addr] = d; else ref_a[addr] = d;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic push_beats();
    beat_t b;
    for (int i = 0; i < 2*SIZE; i++) begin
      b.sel  = (i >= SIZE);
      b.last = ((i % SIZE) == SIZE-1);
      b.data = b.sel ? ref_b[i-SIZE] : ref_a[i];
      exp_q.push_back(b);
    end
  endtask

  task automatic run_seq(input int rm, input int am, input logic [1:0] exp_err, input bit chk_sched);
    int n;
    int unsigned go_cyc, done_cyc;
    rdy_mode = rm; acc_mode = am;
    push_beats();
    if (am != 2) matmul(ref_a, ref_b, exp_r);
    @(posedge clk); #1 go = 1'b1;
    @(negedge clk) go_cyc = cyc;
    @(posedge clk); #1 go = 1'b0;
    n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    done_cyc = cyc;
    chk("done_seen", 64'(done), 64'(1));
    chk("err", 64'(err), 64'(exp_err));
    chk("busy_low", 64'(busy), 64'(0));
    chk("start_once", 64'(start_cnt), 64'(1));
    chk("stream_drained", 64'(exp_q.size()), 64'(0));
    if (am == 2) chk("timeout_latency", 64'(done_cyc - start_cyc), 64'(TMO + 1));
    else         chk("done_latency", 64'(done_cyc - last_s_cyc), 64'(1));
    if (chk_sched) chk("start_cycle", 64'(start_cyc - go_cyc), 64'(2*SIZE + 1));
    for (int i = 0; i < SIZE; i++) begin
      @(posedge clk); #1 rd_addr = SL'(i);
      @(posedge clk);
      @(negedge clk) chk("rd_data", 64'(rd_data), 64'(exp_r[i]));
    end
    chk("done_held", 64'(done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < SIZE; i++) exp_r[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'({busy, done, err, start, sel, m_if.tvalid, m_if.tlast, s_if.tready}), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("tstrb", 64'(m_if.tstrb), 64'(4'hF));
    @(posedge clk); #1 rst = 1'b0;

    // Known 2x2 case: [1 2;3 4]*[5 6;7 8] = [19 22;43 50]
    for (int i = 0; i < SIZE; i++) begin
      write_op(1'b0, i, DW'(i + 1));
      write_op(1'b1, i, DW'(i + 5));
    end
    run_seq(0, 0, 2'b00, 1);
    chk("known_r3", 64'(exp_r[3]), 64'(50));
    run_seq(1, 0, 2'b00, 0);
    run_seq(2, 1, 2'b01, 0);
    run_seq(0, 2, 2'b10, 0);

    // Reset in the middle of SEND_B
    rdy_mode = 1;
    push_beats();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    n = 0;
    while (!(m_if.tvalid && sel) && n < 100) begin @(negedge clk); n++; end
    chk("reached_send_b", 64'(m_if.tvalid && sel), 64'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", 64'({busy, done, err, start, sel, m_if.tvalid, m_if.tlast, s_if.tready}), 64'(0));
    chk("midrst_rd_data", 64'(rd_data), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    run_seq(2, 0, 2'b00, 0);

    // Ignored write during SEND_A and ignored go during RECV
    dist_wr = 1; dist_go = 1;
    run_seq(1, 0, 2'b00, 0);
    run_seq(0, 0, 2'b00, 0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < SIZE; i++) begin
        write_op(1'b0, i, $urandom);
        write_op(1'b1, i, $urandom);
      end
      run_seq(2, 0, 2'b00, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
